// File: rtl/psram_resp_model_pkg.sv
// Shared constants and types for the octal DDR PSRAM responder.
// Command codes, FSM states and mode-register indices.
package psram_resp_model_pkg;

  localparam logic [7:0] PSRAM_CMD_MRD = 8'h00;
  localparam logic [7:0] PSRAM_CMD_MWR = 8'h80;
  localparam logic [7:0] PSRAM_CMD_RRD = 8'h40;
  localparam logic [7:0] PSRAM_CMD_RWR = 8'hC0;

  localparam int PSRAM_ADDR_BYTES = 4;

  localparam logic [2:0] MR_LAT = 3'd0;
  localparam logic [2:0] MR_ID  = 3'd1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_LAT,
    ST_RDATA,
    ST_WDATA,
    ST_ERR
  } state_t;

  function automatic logic cmd_legal(
    input logic [7:0] c
  );
    logic ok;
    ok = 1'b0;
    unique case (1'b1)
      (c == PSRAM_CMD_MRD): ok = 1'b1;
      (c == PSRAM_CMD_MWR): ok = 1'b1;
      (c == PSRAM_CMD_RRD): ok = 1'b1;
      (c == PSRAM_CMD_RWR): ok = 1'b1;
      default:              ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/psram_resp_sync.sv
// Pad-side input synchroniser for the PSRAM responder.
// All pad inputs share one 2-flop path so they stay aligned.
module psram_resp_sync (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       sck_i,
  input  logic       ce_i,
  input  logic       dqs_i,
  input  logic [7:0] io_i,
  output logic       sck_edge_o,
  output logic       ce_fall_o,
  output logic       ce_rise_o,
  output logic       ce_o,
  output logic       dqs_o,
  output logic [7:0] io_o
);

  localparam logic [10:0] RST_V = {1'b0, 1'b1, 1'b0, 8'h00};

  logic [10:0] r_s1;
  logic [10:0] r_s2;
  logic        r_sck_d;
  logic        r_ce_d;

  // two-stage sync plus delayed copies for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_s1    <= RST_V;
      r_s2    <= RST_V;
      r_sck_d <= 1'b0;
      r_ce_d  <= 1'b1;
    end else begin
      r_s1    <= {sck_i, ce_i, dqs_i, io_i};
      r_s2    <= r_s1;
      r_sck_d <= r_s2[10];
      r_ce_d  <= r_s2[9];
    end
  end

  assign sck_edge_o = r_s2[10] ^ r_sck_d;
  assign ce_fall_o  = r_ce_d & ~r_s2[9];
  assign ce_rise_o  = ~r_ce_d & r_s2[9];
  assign ce_o       = r_s2[9];
  assign dqs_o      = r_s2[8];
  assign io_o       = r_s2[7:0];

endmodule

// File: rtl/psram_resp_model.sv
// Octal DDR PSRAM device-side responder.
// Decodes cmd/addr on both SCK edges, returns edge-aligned read data.
module psram_resp_model
  import psram_resp_model_pkg::*;
#(
  parameter int         ADDR_WIDTH = 12,
  parameter logic [3:0] LAT_DEF    = 4'd5,
  parameter logic [7:0] ID_VAL     = 8'h0D
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic [7:0] err_cnt_o
);

  logic       w_edge;
  logic       w_ce_fall;
  logic       w_ce_rise;
  logic       w_ce;
  logic       w_dqs;
  logic [7:0] w_io;

  psram_resp_sync u_sync (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .sck_i      (psram_sck_i),
    .ce_i       (psram_ce_i),
    .dqs_i      (psram_dqs_in_i),
    .io_i       (psram_io_in_i),
    .sck_edge_o (w_edge),
    .ce_fall_o  (w_ce_fall),
    .ce_rise_o  (w_ce_rise),
    .ce_o       (w_ce),
    .dqs_o      (w_dqs),
    .io_o       (w_io)
  );

  state_t                r_state;
  state_t                w_next;
  logic                  r_is_rd;
  logic                  r_is_reg;
  logic [1:0]            r_acnt;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH-1:0] w_ptr_nxt;
  logic [4:0]            r_lat_cnt;
  logic [4:0]            w_lat;
  logic [7:0]            r_mr [8];
  logic [7:0]            r_mem [2**ADDR_WIDTH];
  logic                  r_drv;
  logic                  r_dqs;
  logic [7:0]            r_io_out;
  logic [7:0]            r_err;
  logic [7:0]            w_rd_byte;
  state_t                w_data_st;

  logic w_legal;
  logic w_cmd_ok;
  logic w_cmd_bad;
  logic w_addr_edge;
  logic w_addr_done;
  logic w_lat_edge;
  logic w_lat_done;
  logic w_drv_on;
  logic w_beat;
  logic w_rd_beat;
  logic w_wr_mem;
  logic w_wr_reg;

  assign w_lat     = {r_mr[MR_LAT][3:0], 1'b0};
  assign w_data_st = r_is_rd ? ST_RDATA : ST_WDATA;
  assign w_legal   = cmd_legal(w_io);

  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  // next-state decode; CE rise aborts from anywhere
  always_comb begin
    w_next = r_state;
    if (w_ce_rise) begin
      w_next = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE:
          if (w_ce_fall) w_next = ST_CMD;
        ST_CMD:
          if (w_edge) w_next = w_legal ? ST_ADDR : ST_ERR;
        ST_ADDR:
          if (w_addr_done)
            w_next = (w_lat == 5'd0) ? w_data_st : ST_LAT;
        ST_LAT:
          if (w_lat_done) w_next = w_data_st;
        ST_RDATA, ST_WDATA, ST_ERR:
          w_next = r_state;
        default:
          w_next = ST_IDLE;
      endcase
    end
  end

  // per-cycle control strobes derived from state and edge
  always_comb begin
    w_cmd_ok    = 1'b0;
    w_cmd_bad   = 1'b0;
    w_addr_edge = 1'b0;
    w_lat_edge  = 1'b0;
    w_beat      = 1'b0;
    if (!w_ce_rise && w_edge) begin
      w_cmd_ok    = (r_state == ST_CMD) && w_legal;
      w_cmd_bad   = (r_state == ST_CMD) && !w_legal;
      w_addr_edge = (r_state == ST_ADDR);
      w_lat_edge  = (r_state == ST_LAT);
      w_beat      = (r_state == ST_RDATA) || (r_state == ST_WDATA);
    end
    w_addr_done = w_addr_edge && (r_acnt == 2'(PSRAM_ADDR_BYTES - 1));
    w_lat_done  = w_lat_edge && (r_lat_cnt == 5'd1);
    w_drv_on    = r_is_rd &&
                  ((w_addr_done && (w_lat == 5'd0)) || w_lat_done);
    w_rd_beat   = w_beat && (r_state == ST_RDATA);
    w_wr_mem    = w_beat && (r_state == ST_WDATA) && !w_dqs && !r_is_reg;
    w_wr_reg    = w_beat && (r_state == ST_WDATA) && !w_dqs && r_is_reg &&
                  (r_ptr[2:0] != MR_ID);
  end

  // pointer step: registers wrap in 8, memory in the array size
  always_comb begin
    w_ptr_nxt = r_ptr + 1'b1;
    if (r_is_reg) begin
      w_ptr_nxt      = '0;
      w_ptr_nxt[2:0] = r_ptr[2:0] + 3'd1;
    end
  end

  // read-data mux: MR1 is the fixed device ID
  always_comb begin
    w_rd_byte = r_mem[r_ptr];
    if (r_is_reg)
      w_rd_byte = (r_ptr[2:0] == MR_ID) ? ID_VAL : r_mr[r_ptr[2:0]];
  end

  // transaction datapath, mode registers and pad drivers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_is_rd   <= 1'b0;
      r_is_reg  <= 1'b0;
      r_acnt    <= '0;
      r_ptr     <= '0;
      r_lat_cnt <= '0;
      r_drv     <= 1'b0;
      r_dqs     <= 1'b0;
      r_io_out  <= '0;
      r_err     <= '0;
      for (int i = 0; i < 8; i++) r_mr[i] <= '0;
      r_mr[MR_LAT] <= {4'h0, LAT_DEF};
    end else begin
      if (w_cmd_ok) begin
        r_is_rd  <= (w_io == PSRAM_CMD_MRD) || (w_io == PSRAM_CMD_RRD);
        r_is_reg <= (w_io == PSRAM_CMD_RRD) || (w_io == PSRAM_CMD_RWR);
        r_acnt   <= '0;
      end
      if (w_cmd_bad && (r_err != 8'hFF))
        r_err <= r_err + 8'd1;
      if (w_addr_edge) begin
        r_acnt <= r_acnt + 2'd1;
        r_ptr  <= ADDR_WIDTH'({r_ptr, w_io});
        if (w_addr_done) begin
          r_lat_cnt <= w_lat;
          if (r_is_reg) begin
            r_ptr      <= '0;
            r_ptr[2:0] <= w_io[2:0];
          end
        end
      end
      if (w_lat_edge)
        r_lat_cnt <= r_lat_cnt - 5'd1;
      if (w_beat)
        r_ptr <= w_ptr_nxt;
      if (w_wr_reg)
        r_mr[r_ptr[2:0]] <= w_io;
      if (w_ce_rise) begin
        r_drv <= 1'b0;
        r_dqs <= 1'b0;
      end else if (w_drv_on) begin
        r_drv <= 1'b1;
        r_dqs <= 1'b0;
      end else if (w_rd_beat) begin
        r_io_out <= w_rd_byte;
        r_dqs    <= ~r_dqs;
      end
    end
  end

  // byte array write port; contents survive reset
  always_ff @(posedge clk_i) begin
    if (w_wr_mem) r_mem[r_ptr] <= w_io;
  end

  assign psram_io_out_o  = r_io_out;
  assign psram_io_en_o   = {8{r_drv}};
  assign psram_dqs_out_o = r_dqs;
  assign psram_dqs_en_o  = r_drv;
  assign busy_o          = ~w_ce;
  assign err_cnt_o       = r_err;

endmodule

// File: tb/tb_psram_resp_model.sv
// Randomised bench for psram_resp_model.
// Acts as the controller and checks against a byte-level memory model.
module tb_psram_resp_model;

  localparam int AW = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sck = 1'b0;
  logic       ce = 1'b1;
  logic [7:0] io_in = 8'h00;
  logic       dqs_in = 1'b0;
  logic [7:0] io_out;
  logic [7:0] io_en;
  logic       dqs_out;
  logic       dqs_en;
  logic       busy;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  psram_resp_model #(
    .ADDR_WIDTH (AW),
    .LAT_DEF    (4'd5),
    .ID_VAL     (8'h0D)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .psram_sck_i     (sck),
    .psram_ce_i      (ce),
    .psram_io_in_i   (io_in),
    .psram_io_out_o  (io_out),
    .psram_io_en_o   (io_en),
    .psram_dqs_in_i  (dqs_in),
    .psram_dqs_out_o (dqs_out),
    .psram_dqs_en_o  (dqs_en),
    .busy_o          (busy),
    .err_cnt_o       (err_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] m_mem [2**AW];
  bit         m_known [2**AW];
  logic [7:0] m_mr [8];
  int         m_err = 0;

  logic [7:0] tx_wd [16];
  bit         tx_mk [16];
  logic [7:0] rd_buf [16];

  logic [7:0] s_io;
  logic [7:0] s_en;
  logic       s_dqs;
  logic       s_dqs_en;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mr[i] = 8'h00;
    m_mr[0] = 8'h05;
    m_err = 0;
  endtask

  function automatic int model_lat();
    return 2 * int'(m_mr[0][3:0]);
  endfunction

  function automatic logic [7:0] model_reg(input logic [2:0] i);
    return (i == 3'd1) ? 8'h0D : m_mr[i];
  endfunction

  // one SCK transition carrying byte b; sample once drivers settle
  task automatic sck_edge(input logic [7:0] b, input logic m);
    io_in  = b;
    dqs_in = m;
    sck    = ~sck;
    repeat (6) @(posedge clk);
    @(negedge clk);
    s_io     = io_out;
    s_en     = io_en;
    s_dqs    = dqs_out;
    s_dqs_en = dqs_en;
  endtask

  task automatic ce_low();
    ce = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_hi", 32'(busy), 32'd1);
  endtask

  task automatic ce_high();
    ce = 1'b1;
    repeat (5) @(negedge clk);
    chk("en_off", 32'(io_en), 32'h0);
    chk("dqsen_off", 32'(dqs_en), 32'h0);
    chk("busy_lo", 32'(busy), 32'd0);
  endtask

  task automatic xfer(input logic [7:0] cmd, input logic [31:0] addr,
                      input int n);
    bit         rd;
    bit         rg;
    int         lat;
    logic [AW-1:0] p;
    rd  = (cmd == 8'h00) || (cmd == 8'h40);
    rg  = cmd[6];
    lat = model_lat();
    ce_low();
    sck_edge(cmd, 1'b0);
    for (int i = 0; i < 4; i++) begin
      sck_edge(addr[31-8*i -: 8], 1'b0);
    end
    chk("en_addr", 32'(s_en), (rd && lat == 0) ? 32'hFF : 32'h0);
    for (int i = 1; i <= lat; i++) begin
      sck_edge(8'($urandom), 1'b0);
      chk("en_lat", 32'(s_en), (rd && i == lat) ? 32'hFF : 32'h0);
    end
    p = rg ? AW'(addr[2:0]) : addr[AW-1:0];
    for (int k = 0; k < n; k++) begin
      if (rd) begin
        sck_edge(8'($urandom), 1'b0);
        rd_buf[k] = s_io;
        if (rg)
          chk("reg_rd", 32'(s_io), 32'(model_reg(p[2:0])));
        else if (m_known[p])
          chk("mem_rd", 32'(s_io), 32'(m_mem[p]));
        chk("dqs_par", 32'(s_dqs), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("en_rd", 32'({s_dqs_en, s_en}), 32'h1FF);
      end else begin
        sck_edge(tx_wd[k], tx_mk[k]);
        if (!tx_mk[k]) begin
          if (rg) begin
            if (p[2:0] != 3'd1) m_mr[p[2:0]] = tx_wd[k];
          end else begin
            m_mem[p]   = tx_wd[k];
            m_known[p] = 1'b1;
          end
        end
      end
      if (rg) p = AW'(3'(p[2:0] + 3'd1));
      else    p = p + 1'b1;
    end
    ce_high();
  endtask

  task automatic set_wd(input logic [31:0] d, input logic [3:0] mk);
    for (int i = 0; i < 4; i++) begin
      tx_wd[i] = d[31-8*i -: 8];
      tx_mk[i] = mk[3-i];
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  logic [31:0] last_wr;
  int          op;
  int          n;
  logic [7:0]  c;

  initial begin
    for (int i = 0; i < 2**AW; i++) m_known[i] = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_io", 32'(io_out), 32'h0);
    chk("rst_en", 32'(io_en), 32'h0);
    chk("rst_dqs", 32'(dqs_out), 32'h0);
    chk("rst_dqsen", 32'(dqs_en), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err_cnt), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    xfer(8'h40, 32'h0, 2);
    chk("mr0_rst", 32'(rd_buf[0]), 32'h05);
    chk("mr1_id", 32'(rd_buf[1]), 32'h0D);

    set_wd(32'h11223344, 4'b0000);
    xfer(8'h80, 32'h10, 4);
    xfer(8'h00, 32'h10, 4);
    chk("wr_rd", 32'({rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3]}),
        32'h11223344);

    set_wd(32'h0, 4'b0000);
    xfer(8'h80, 32'h20, 4);
    set_wd(32'hAABBCCDD, 4'b0100);
    xfer(8'h80, 32'h20, 4);
    xfer(8'h00, 32'h20, 4);
    chk("mask", 32'({rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3]}),
        32'hAA00CCDD);

    set_wd(32'h5566_7788, 4'b0000);
    xfer(8'h80, 32'h0FFE, 4);
    xfer(8'h00, 32'h0000, 2);
    chk("wrap", 32'({rd_buf[0], rd_buf[1]}), 32'h7788);

    tx_wd[0] = 8'h03; tx_mk[0] = 1'b0;
    xfer(8'hC0, 32'h0, 1);
    xfer(8'h00, 32'h10, 2);
    tx_wd[0] = 8'h00;
    xfer(8'hC0, 32'h0, 1);
    xfer(8'h00, 32'h10, 2);
    tx_wd[0] = 8'h77;
    xfer(8'hC0, 32'h1, 1);
    xfer(8'h40, 32'h1, 1);
    chk("mr1_ro", 32'(rd_buf[0]), 32'h0D);

    ce_low();
    sck_edge(8'h5A, 1'b0);
    m_err++;
    for (int i = 0; i < 4; i++) begin
      sck_edge(8'($urandom), 1'b0);
      chk("err_en", 32'(s_en), 32'h0);
    end
    ce_high();
    chk("err_cnt", 32'(err_cnt), 32'd1);

    ce_low();
    sck_edge(8'h80, 1'b0);
    sck_edge(8'h00, 1'b0);
    sck_edge(8'h00, 1'b0);
    ce_high();
    for (int i = 0; i < 6; i++) sck_edge(8'hFF, 1'b0);
    xfer(8'h00, 32'h10, 4);
    chk("abort", 32'({rd_buf[0], rd_buf[1], rd_buf[2], rd_buf[3]}),
        32'h11223344);

    last_wr = 32'h10;
    for (int t = 0; t < 24; t++) begin
      op = $urandom_range(0, 5);
      n  = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        tx_wd[i] = 8'($urandom);
        tx_mk[i] = ($urandom_range(0, 3) == 0);
      end
      unique case (op)
        0, 1: begin
          last_wr = $urandom;
          xfer(8'h80, last_wr, n);
        end
        2:    xfer(8'h00, ($urandom_range(0, 1) != 0) ? last_wr : $urandom, n);
        3: begin
          tx_wd[0] = {4'($urandom), 4'($urandom_range(0, 4))};
          xfer(8'hC0, 32'($urandom_range(0, 7)), n);
        end
        4:    xfer(8'h40, 32'($urandom_range(0, 7)), n);
        default: begin
          c = 8'($urandom);
          if (c == 8'h00 || c == 8'h80 || c == 8'h40 || c == 8'hC0)
            c = 8'h5A;
          ce_low();
          sck_edge(c, 1'b0);
          sck_edge(8'h00, 1'b0);
          chk("rerr_en", 32'(s_en), 32'h0);
          ce_high();
          if (m_err < 255) m_err++;
          chk("rerr_cnt", 32'(err_cnt), 32'(m_err));
        end
      endcase
    end

    ce_low();
    sck_edge(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) sck_edge((i == 3) ? 8'h10 : 8'h00, 1'b0);
    for (int i = 0; i < model_lat(); i++) sck_edge(8'h00, 1'b0);
    sck_edge(8'h00, 1'b0);
    chk("pre_rst_en", 32'(s_en), 32'hFF);
    rst_n = 1'b0;
    #1;
    chk("arst_en", 32'(io_en), 32'h0);
    chk("arst_dqsen", 32'(dqs_en), 32'h0);
    chk("arst_dqs", 32'(dqs_out), 32'h0);
    ce = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    xfer(8'h40, 32'h0, 1);
    chk("mr0_rst2", 32'(rd_buf[0]), 32'h05);
    xfer(8'h00, 32'h10, 4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
